// File: rtl/osd_pkg.sv
// Shared sizing helpers and types for the OSD overlay: bitmap geometry, RAM
// address widths and the display-bank encoding.
package osd_pkg;

  localparam int unsigned WORD_BITS = 32;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bitmap words per overlay row.
  function automatic int unsigned osd_wpr(input int unsigned box_w);
    return box_w / WORD_BITS;
  endfunction

  function automatic int unsigned osd_bank_depth(input int unsigned box_w,
                                                 input int unsigned box_h);
    return box_h * osd_wpr(box_w);
  endfunction

  function automatic int unsigned osd_bank_aw(input int unsigned box_w,
                                              input int unsigned box_h);
    return clog2_min1(osd_bank_depth(box_w, box_h));
  endfunction

  // Both banks live in one RAM: bank 1 starts at offset bank_depth.
  function automatic int unsigned osd_ram_aw(input int unsigned box_w,
                                             input int unsigned box_h);
    return clog2_min1(2 * osd_bank_depth(box_w, box_h));
  endfunction

  // Write pointer must be able to hold bank_depth itself (the "full" value).
  function automatic int unsigned osd_wptr_w(input int unsigned box_w,
                                             input int unsigned box_h);
    return clog2_min1(osd_bank_depth(box_w, box_h) + 1);
  endfunction

endpackage

// File: rtl/osd_overlay_vg_if.sv
// Bitmap write bus of the OSD overlay: word stream, commit pulse and the
// sticky overflow flag returned by the overlay.
interface osd_overlay_vg_if;
  import osd_pkg::*;

  logic                 wr_en;
  logic [WORD_BITS-1:0] wr_data;
  logic                 wr_commit;
  logic                 wr_ovf;

  modport master (output wr_en, output wr_data, output wr_commit, input wr_ovf);
  modport slave  (input wr_en, input wr_data, input wr_commit, output wr_ovf);
endinterface

// File: rtl/osd_bitmap_ram.sv
// Simple dual-port bitmap RAM, single clock, one-cycle registered read.
// Contents are not reset.
module osd_bitmap_ram
  import osd_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/osd_overlay_vg.sv
// Double-buffered 1bpp bitmap overlay on a video stream, 2-cycle pixel latency.
// Optional macro OSD_ALPHA_EN: glyph pixels become a 50/50 blend of fg and bg.
module osd_overlay_vg
  import osd_pkg::*;
#(
  parameter int unsigned COLOR_DEPTH = 8,
  parameter int unsigned X_BITS      = 13,
  parameter int unsigned Y_BITS      = 13,
  parameter int unsigned BOX_W       = 256,
  parameter int unsigned BOX_H       = 32
) (
  input  logic                     pix_clk,
  input  logic                     rstn,
  input  logic [X_BITS-1:0]        act_x,
  input  logic [Y_BITS-1:0]        act_y,
  input  logic                     vs_in,
  input  logic                     hs_in,
  input  logic                     de_in,
  input  logic [3*COLOR_DEPTH-1:0] bg_data,
  input  logic [X_BITS-1:0]        cfg_x,
  input  logic [Y_BITS-1:0]        cfg_y,
  input  logic [3*COLOR_DEPTH-1:0] fg_color,
  input  logic                     osd_en,
  osd_overlay_vg_if.slave          wr_bus,
  output logic                     vs_out,
  output logic                     hs_out,
  output logic                     de_out,
  output logic [COLOR_DEPTH-1:0]   r_out,
  output logic [COLOR_DEPTH-1:0]   g_out,
  output logic [COLOR_DEPTH-1:0]   b_out
);

  localparam int unsigned WPR        = osd_wpr(BOX_W);
  localparam int unsigned BANK_DEPTH = osd_bank_depth(BOX_W, BOX_H);
  localparam int unsigned AW         = osd_bank_aw(BOX_W, BOX_H);
  localparam int unsigned RAW        = osd_ram_aw(BOX_W, BOX_H);
  localparam int unsigned WAW        = osd_wptr_w(BOX_W, BOX_H);
  localparam int unsigned PW         = 3 * COLOR_DEPTH;
  localparam int unsigned XW         = X_BITS + 1;
  localparam int unsigned YW         = Y_BITS + 1;

  // ---------------- bank control / write side ----------------
  logic           vs_d;
  logic           vs_rise;
  logic           swap;
  logic           wr_full;
  logic           wr_fire;
  bank_e          disp_bank;
  logic           pending;
  logic [WAW-1:0] wr_addr;
  logic           wr_ovf_r;
  logic [RAW-1:0] ram_waddr;

  always_comb begin
    vs_rise   = vs_in & ~vs_d;
    swap      = vs_rise & (pending | wr_bus.wr_commit);
    wr_full   = (wr_addr == WAW'(BANK_DEPTH));
    wr_fire   = wr_bus.wr_en & ~wr_full;
    ram_waddr = (disp_bank == BANK_0) ? RAW'(BANK_DEPTH) + RAW'(wr_addr)
                                      : RAW'(wr_addr);
  end

  // A write coincident with a swap still lands in the old back bank (ram_waddr
  // uses the pre-swap disp_bank); the swap then rewinds the pointer.
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      vs_d      <= 1'b0;
      disp_bank <= BANK_0;
      pending   <= 1'b0;
      wr_addr   <= '0;
      wr_ovf_r  <= 1'b0;
    end else begin
      vs_d <= vs_in;
      if (swap) begin
        disp_bank <= (disp_bank == BANK_0) ? BANK_1 : BANK_0;
        pending   <= 1'b0;
        wr_addr   <= '0;
        wr_ovf_r  <= 1'b0;
      end else begin
        if (wr_bus.wr_commit) pending <= 1'b1;
        if (wr_fire)            wr_addr  <= wr_addr + WAW'(1);
        else if (wr_bus.wr_en)  wr_ovf_r <= 1'b1;
      end
    end
  end

  assign wr_bus.wr_ovf = wr_ovf_r;

  // ---------------- frame-synchronous configuration ----------------
  logic [X_BITS-1:0] cfg_x_s;
  logic [Y_BITS-1:0] cfg_y_s;
  logic [PW-1:0]     fg_s;
  logic              en_s;

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      cfg_x_s <= '0;
      cfg_y_s <= '0;
      fg_s    <= '0;
      en_s    <= 1'b0;
    end else if (vs_rise) begin
      cfg_x_s <= cfg_x;
      cfg_y_s <= cfg_y;
      fg_s    <= fg_color;
      en_s    <= osd_en;
    end
  end

  // ---------------- hit test and read address ----------------
  logic [XW-1:0]  x_pos, x_lo, x_hi, col;
  logic [YW-1:0]  y_pos, y_lo, y_hi, row;
  logic           hit0;
  logic [AW-1:0]  rd_off;
  logic [RAW-1:0] ram_raddr;

  always_comb begin
    x_pos     = {1'b0, act_x};
    x_lo      = {1'b0, cfg_x_s};
    x_hi      = x_lo + XW'(BOX_W);
    y_pos     = {1'b0, act_y};
    y_lo      = {1'b0, cfg_y_s};
    y_hi      = y_lo + YW'(BOX_H);
    col       = x_pos - x_lo;
    row       = y_pos - y_lo;
    hit0      = en_s & (x_pos >= x_lo) & (x_pos < x_hi)
                     & (y_pos >= y_lo) & (y_pos < y_hi);
    rd_off    = AW'(row) * AW'(WPR) + AW'(col >> 5);
    ram_raddr = (disp_bank == BANK_1) ? RAW'(BANK_DEPTH) + RAW'(rd_off)
                                      : RAW'(rd_off);
  end

  logic [WORD_BITS-1:0] ram_rdata;

  osd_bitmap_ram #(
    .DEPTH (2 * BANK_DEPTH),
    .AW    (RAW)
  ) u_ram (
    .clk   (pix_clk),
    .we    (wr_fire),
    .waddr (ram_waddr),
    .wdata (wr_bus.wr_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // ---------------- stage 1: aligns with the registered RAM read ----------------
  logic          hit1;
  logic [4:0]    bit1;
  logic [PW-1:0] bg1;
  logic [PW-1:0] fg1;
  logic          vs1, hs1, de1;

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      hit1 <= 1'b0;
      bit1 <= '0;
      bg1  <= '0;
      fg1  <= '0;
      vs1  <= 1'b0;
      hs1  <= 1'b0;
      de1  <= 1'b0;
    end else begin
      hit1 <= hit0;
      bit1 <= col[4:0];
      bg1  <= bg_data;
      fg1  <= fg_s;
      vs1  <= vs_in;
      hs1  <= hs_in;
      de1  <= de_in;
    end
  end

  // ---------------- stage 2: pixel select ----------------
  logic          glyph;
  logic [PW-1:0] pix_mix;
  logic [PW-1:0] pix_q;
`ifdef OSD_ALPHA_EN
  logic [COLOR_DEPTH:0] ch_sum;
`endif

  always_comb begin
    glyph   = hit1 & ram_rdata[5'd31 - bit1];
    pix_mix = fg1;
`ifdef OSD_ALPHA_EN
    ch_sum  = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      ch_sum = {1'b0, fg1[ch*COLOR_DEPTH +: COLOR_DEPTH]}
             + {1'b0, bg1[ch*COLOR_DEPTH +: COLOR_DEPTH]};
      pix_mix[ch*COLOR_DEPTH +: COLOR_DEPTH] = ch_sum[COLOR_DEPTH:1];
    end
`endif
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      pix_q  <= '0;
      vs_out <= 1'b0;
      hs_out <= 1'b0;
      de_out <= 1'b0;
    end else begin
      pix_q  <= glyph ? pix_mix : bg1;
      vs_out <= vs1;
      hs_out <= hs1;
      de_out <= de1;
    end
  end

  assign {r_out, g_out, b_out} = pix_q;

endmodule

// File: doc/osd_overlay_vg.md
OSD_OVERLAY_VG -- requirements
Module: osd_overlay_vg

Interface
REQ-001 SHALL have parameter COLOR_DEPTH, default 8, meaning bits per colour channel.
REQ-002 SHALL have parameter X_BITS, default 13, meaning width of act_x and cfg_x.
REQ-003 SHALL have parameter Y_BITS, default 13, meaning width of act_y and cfg_y.
REQ-004 SHALL have parameter BOX_W, default 256, meaning overlay width in pixels, a multiple of 32.
REQ-005 SHALL have parameter BOX_H, default 32, meaning overlay height in lines.
REQ-006 SHALL have port pix_clk, input, 1, the only clock.
REQ-007 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports act_x/act_y, input, X_BITS/Y_BITS, active-area pixel coordinate.
REQ-009 SHALL have ports vs_in, hs_in, de_in, input, 1 each, timing; vs_in is active-high.
REQ-010 SHALL have port bg_data, input, 3*COLOR_DEPTH, background pixel {R,G,B}.
REQ-011 SHALL have ports cfg_x/cfg_y, input, X_BITS/Y_BITS, overlay top-left corner.
REQ-012 SHALL have port fg_color, input, 3*COLOR_DEPTH, glyph colour.
REQ-013 SHALL have port osd_en, input, 1, overlay enable.
REQ-014 SHALL have ports wr_en, input, 1, and wr_data, input, 32, bitmap word write.
REQ-015 SHALL have port wr_commit, input, 1, a single-cycle pulse that commits the written bitmap.
REQ-016 SHALL have ports vs_out, hs_out, de_out, output, 1 each, delayed timing.
REQ-017 SHALL have ports r_out, g_out, b_out, output, COLOR_DEPTH each, output pixel.
REQ-018 SHALL have port wr_ovf, output, 1, sticky write-overflow flag.

Function
REQ-019 SHALL hold two bitmap banks, each BOX_H*WPR 32-bit words, where WPR=BOX_W/32; word (row r, word w) is at address r*WPR+w.
REQ-020 SHALL map pixel column c to word c/32, bit 31-(c%32); a set bit marks a glyph pixel.
REQ-021 SHALL write wr_data to the back bank (bank != disp_bank) at wr_addr when wr_en is high, then increment wr_addr.
REQ-022 SHALL drop wr_en at wr_addr == BOX_H*WPR without writing, set wr_ovf and hold wr_addr.
REQ-023 SHALL set a pending flag on wr_commit.
REQ-024 SHALL, on a vs_in rising edge with the pending flag set (or wr_commit high in the same cycle), toggle disp_bank, clear pending, zero wr_addr and clear wr_ovf.
REQ-025 SHALL apply a wr_en coincident with a swap edge to the old back bank, and SHALL reset wr_addr to 0 regardless.
REQ-026 SHALL define hit = osd_en & act_x in [cfg_x, cfg_x+BOX_W) & act_y in [cfg_y, cfg_y+BOX_H), computed at X_BITS+1/Y_BITS+1 width so the sum does not wrap.
REQ-027 SHALL have a 2-cycle latency: stage 1 registers the read address, hit, bit index and bg_data; stage 2 registers the output pixel.
REQ-028 SHALL output fg_color when the stage-1 hit is set and the selected bit is 1; otherwise SHALL output the delayed bg_data.
REQ-029 SHALL delay vs, hs and de by exactly 2 cycles to match the pixel.
REQ-030 SHALL sample cfg_x, cfg_y, fg_color and osd_en into shadow registers on a vs_in rising edge only, so there is no mid-frame tearing.

Reset
REQ-031 SHALL, on rstn low, immediately clear all outputs, disp_bank, pending, wr_addr, wr_ovf, the pipeline and the shadow registers (osd_en shadow = 0).
REQ-032 SHALL leave bitmap RAM contents undefined after reset.
REQ-033 SHALL discard a commit pending at reset.

Configuration
REQ-034 SHALL support macro OSD_ALPHA_EN.
REQ-035 SHALL, when OSD_ALPHA_EN is defined, output each glyph-pixel channel as (fg+bg)>>1 with a (COLOR_DEPTH+1)-bit sum; the 2-cycle latency is unchanged.
REQ-036 SHALL, when OSD_ALPHA_EN is undefined, output glyph pixels opaquely as fg_color.

Structure
REQ-037 SHALL place the WPR, bank depth and RAM address width computations in the shared package osd_pkg.
REQ-038 SHALL implement the bitmap as sub-module osd_bitmap_ram: single-clock simple dual-port, 32-bit wide, depth 2*BOX_H*WPR, 1-cycle registered read.

Verification
REQ-039 SHALL test: write 256 words of 0xFFFFFFFF, commit, vs edge, cfg=(100,10) -> pixels x 100..355, y 10..41 equal fg_color; pixel (99,10) equals bg_data.
REQ-040 SHALL test: row 0 word 0 = 0x80000001 -> only columns 0 and 31 of row 0 are glyph pixels, each appearing 2 cycles after its act_x.
REQ-041 SHALL test: 257 writes -> wr_ovf=1 and word 256 is not written; the next swap clears wr_ovf.
REQ-042 SHALL test: wr_commit in the same cycle as the vs rising edge -> swap that edge; displayed bank changes in the next frame.
REQ-043 SHALL test: cfg_x changed mid-frame -> overlay position changes only after the next vs edge.
REQ-044 SHALL test: with OSD_ALPHA_EN, fg=0xFF0000 and bg=0x0000FF -> output 0x7F007F.
